udp_payload_buffer: RTL and testbench
=====================================

// Module: udp_payload_buffer
// PURPOSE
//  Single-packet payload store upstream of eth_udp_tx_gmii. Accepts a byte stream with an
//  end-of-packet marker, holds one complete UDP payload and launches the transmitter.
//  Supplies data_len and tx_en_pulse, then serves payload bytes on payload_req.
//  Replaces hard-coded payload ROMs in the UDP test tops.
// PARAMETERS
//  MAX_LEN  1472  max payload bytes (UDP over 1500 MTU); storage depth
//  ADDR_W   11    pointer width; 2**ADDR_W >= MAX_LEN
//  MIN_LEN  18    min payload bytes when UDP_PAYLOAD_PAD_EN is defined (64-byte frame)
// PORTS
//  clk_125m     in   1   GMII transmit clock; all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  wr_en        in   1   write strobe; byte accepted when wr_en && wr_ready
//  wr_data      in   8   payload byte
//  wr_last      in   1   qualifies wr_en: final byte of packet
//  wr_ready     out  1   buffer accepting bytes
//  wr_drop      out  1   1-cycle pulse: wr_en while !wr_ready, byte discarded
//  wr_trunc     out  1   1-cycle pulse: MAX_LEN reached without wr_last
//  tx_en_pulse  out  1   1-cycle start strobe to eth_udp_tx_gmii
//  data_len     out  16  payload length; stable from tx_en_pulse until tx_done
//  payload_req  in   1   byte request from eth_udp_tx_gmii, high data_len cycles
//  payload_dat  out  8   byte for current request cycle
//  tx_done      in   1   1-cycle pulse, frame finished
//  busy         out  1   high in LAUNCH/SEND/WAIT_DONE
// BEHAVIOUR
//  Reset: state IDLE, wr_ready=1, wr_drop=0, wr_trunc=0, tx_en_pulse=0, data_len=0,
//   payload_dat=0, busy=0, wr_ptr=0, rd_ptr=0.
//  States: IDLE -> FILL on first accepted byte; FILL -> LAUNCH on accepted wr_last or
//   when byte count reaches MAX_LEN (wr_trunc pulses, later bytes dropped);
//   LAUNCH (1 cycle, tx_en_pulse=1) -> SEND; SEND -> WAIT_DONE on falling payload_req;
//   WAIT_DONE -> IDLE on tx_done. tx_done in any non-IDLE state -> IDLE.
//  wr_ready=1 only in IDLE/FILL; cleared in the cycle after the terminating byte.
//  data_len = accepted byte count, registered on entry to LAUNCH, held until IDLE.
//  Read: payload_dat is registered and prefetched; holds mem[0] on LAUNCH exit. Each
//   payload_req cycle shows mem[rd_ptr]; rd_ptr increments, next byte loads by the
//   following edge. Zero-latency w.r.t. req: byte k is valid in the k-th req cycle.
//  Request past data_len: payload_dat=0, rd_ptr saturates at data_len.
//  payload_req outside SEND: ignored, payload_dat unchanged.
//  rd_ptr and wr_ptr reset to 0 on IDLE entry. No wrap-around: one packet at a time.
//  Simultaneous wr_en and tx_done in WAIT_DONE: byte dropped (wr_drop), state -> IDLE.
//  Mid-packet reset: all state cleared, partial packet discarded, no tx_en_pulse.
// CONFIGURATION
//  `UDP_PAYLOAD_PAD_EN defined: packets shorter than MIN_LEN report data_len=MIN_LEN;
//   bytes beyond the written count read as 8'h00.
//  Undefined: data_len equals the written count exactly (minimum 1).
// STRUCTURE
//  eth_udp_pkg: state encoding (IDLE, FILL, LAUNCH, SEND, WAIT_DONE),
//   ETH_UDP_MAX_PAYLOAD=1472, ETH_UDP_MIN_PAYLOAD=18.
//  Sub-module udp_payload_ram: simple dual-port RAM, 8 x 2**ADDR_W, registered read,
//   M9K-inferable; control FSM and pointers stay in udp_payload_buffer.
// TESTING
//  Write "Hello" (5 bytes, wr_last on 'o') -> one tx_en_pulse, data_len=5; 5 req
//   cycles return 48,65,6C,6C,6F; tx_done -> busy=0, wr_ready=1.
//  Write 1500 bytes no wr_last -> wr_trunc at byte 1472, 28 wr_drop pulses,
//   data_len=1472, last served byte equals byte 1471 written.
//  wr_en during SEND -> wr_drop each cycle, buffered data unaffected, wr_ready=0.
//  payload_req held 3 cycles past data_len=4 -> extra bytes 00, no state error.
//  rst_n low after 10 of 20 bytes -> no tx_en_pulse; new 3-byte packet sends data_len=3.
//  PAD_EN build, 5-byte packet -> data_len=18, bytes 5..17 read 00.

Source files
------------

// File: rtl/eth_udp_pkg.sv
// eth_udp_pkg: shared state encoding, payload size limits and length helper
// for the UDP payload buffer and its neighbours on the GMII transmit path.
package eth_udp_pkg;

    localparam int ETH_UDP_MAX_PAYLOAD = 1472;
    localparam int ETH_UDP_MIN_PAYLOAD = 18;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        LAUNCH    = 3'd2,
        SEND      = 3'd3,
        WAIT_DONE = 3'd4
    } buf_state_e;

    function automatic logic [15:0] len_with_floor(input logic [15:0] count,
                                                   input logic [15:0] floor_len);
        return (count < floor_len) ? floor_len : count;
    endfunction

endpackage

// File: rtl/udp_payload_ram.sv
// udp_payload_ram: simple dual-port 8-bit RAM, one write port and one
// registered read port with read enable, shaped for block-RAM inference.
module udp_payload_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] r_mem [0:(2**ADDR_W)-1];
    logic [7:0] r_rd_data;

    // NOTE: neither the array nor its read register is reset; a reset here would stop block-RAM mapping.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/udp_payload_buffer.sv
// udp_payload_buffer: holds one UDP payload, launches eth_udp_tx_gmii and serves bytes
// on payload_req. Define UDP_PAYLOAD_PAD_EN to pad short packets to MIN_LEN zero bytes.
module udp_payload_buffer
    import eth_udp_pkg::*;
#(
    parameter int MAX_LEN = ETH_UDP_MAX_PAYLOAD,
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = ETH_UDP_MIN_PAYLOAD
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        wr_drop,
    output logic        wr_trunc,
    output logic        tx_en_pulse,
    output logic [15:0] data_len,
    input  logic        payload_req,
    output logic [7:0]  payload_dat,
    input  logic        tx_done,
    output logic        busy
);

    // One spare pointer bit so a count equal to the full RAM depth still fits.
    localparam int PTR_W = ADDR_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t MAX_PTR = ptr_t'(MAX_LEN);

`ifdef UDP_PAYLOAD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [15:0] LEN_FLOOR = PAD_EN ? 16'(MIN_LEN) : 16'd1;

    buf_state_e  r_state;
    buf_state_e  w_next_state;
    ptr_t        r_wr_ptr;
    ptr_t        r_rd_ptr;
    ptr_t        w_wr_cnt_next;
    ptr_t        w_rd_ptr_next;
    logic [15:0] r_data_len;
    logic        r_wr_drop;
    logic        r_wr_trunc;
    logic        r_req_d;
    logic        r_rd_zero;
    logic        w_wr_ready;
    logic        w_wr_acc;
    logic        w_wr_full;
    logic        w_wr_term;
    logic        w_to_idle;
    logic        w_req_send;
    logic        w_rd_en;
    logic [7:0]  w_ram_dat;

    assign w_wr_ready    = (r_state == IDLE) || (r_state == FILL);
    assign w_wr_acc      = wr_en && w_wr_ready;
    assign w_wr_cnt_next = r_wr_ptr + PTR_ONE;
    assign w_wr_full     = (w_wr_cnt_next == MAX_PTR);
    assign w_wr_term     = w_wr_acc && (wr_last || w_wr_full);
    assign w_to_idle     = tx_done && (r_state != IDLE);

    // Read address runs one ahead of the byte on payload_dat so each request sees its byte at once.
    assign w_req_send    = payload_req && (r_state == SEND);
    assign w_rd_ptr_next = (w_req_send && (16'(r_rd_ptr) < r_data_len)) ? r_rd_ptr + PTR_ONE
                                                                        : r_rd_ptr;
    assign w_rd_en       = (r_state == LAUNCH) || w_req_send;

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default at the top of the block keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_term) begin
                    w_next_state = LAUNCH;
                end else if (w_wr_acc) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (w_wr_term) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH:    w_next_state = SEND;
            SEND: begin
                if (r_req_d && !payload_req) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: w_next_state = WAIT_DONE;
            default:   w_next_state = IDLE;
        endcase
        if (w_to_idle) begin
            w_next_state = IDLE;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_len <= '0;
            r_wr_drop  <= 1'b0;
            r_wr_trunc <= 1'b0;
            r_req_d    <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_req_d    <= payload_req;
            r_wr_drop  <= wr_en && !w_wr_ready;
            r_wr_trunc <= w_wr_acc && !wr_last && w_wr_full && !w_to_idle;
            // Anything at or past the written count reads as zero: padding and over-requests.
            if (w_rd_en) begin
                r_rd_zero <= (w_rd_ptr_next >= r_wr_ptr);
            end
            if (w_to_idle) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_data_len <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= w_wr_cnt_next;
                end
                if (w_wr_term) begin
                    r_data_len <= len_with_floor(16'(w_wr_cnt_next), LEN_FLOOR);
                end
                r_rd_ptr <= w_rd_ptr_next;
            end
        end
    end

    udp_payload_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk_125m),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_ptr_next[ADDR_W-1:0]),
        .o_rd_data (w_ram_dat)
    );

    assign wr_ready    = w_wr_ready;
    assign wr_drop     = r_wr_drop;
    assign wr_trunc    = r_wr_trunc;
    assign tx_en_pulse = (r_state == LAUNCH);
    assign data_len    = r_data_len;
    assign payload_dat = r_rd_zero ? 8'h00 : w_ram_dat;
    assign busy        = (r_state == LAUNCH) || (r_state == SEND) || (r_state == WAIT_DONE);

endmodule

// File: tb/tb_udp_payload_buffer.sv
// tb_udp_payload_buffer: directed sequence with random payloads, checked against
// a queue-based model of what the transmitter should see for each written packet.
`timescale 1ns/1ps
module tb_udp_payload_buffer;
    import eth_udp_pkg::*;

    localparam int MAX_LEN = ETH_UDP_MAX_PAYLOAD;
    localparam int MIN_LEN = ETH_UDP_MIN_PAYLOAD;
`ifdef UDP_PAYLOAD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic        clk_125m    = 1'b0;
    logic        rst_n       = 1'b1;
    logic        wr_en       = 1'b0;
    logic [7:0]  wr_data     = 8'h00;
    logic        wr_last     = 1'b0;
    logic        payload_req = 1'b0;
    logic        tx_done     = 1'b0;
    logic        wr_ready;
    logic        wr_drop;
    logic        wr_trunc;
    logic        tx_en_pulse;
    logic [15:0] data_len;
    logic [7:0]  payload_dat;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tx_en  = 0;
    int n_drop   = 0;
    int n_trunc  = 0;

    udp_payload_buffer dut (
        .clk_125m    (clk_125m),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .wr_drop     (wr_drop),
        .wr_trunc    (wr_trunc),
        .tx_en_pulse (tx_en_pulse),
        .data_len    (data_len),
        .payload_req (payload_req),
        .payload_dat (payload_dat),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    always #4 clk_125m = ~clk_125m;

    // Pulse counters; the sequence reads them at least #1 after a falling edge.
    always @(negedge clk_125m) begin
        if (tx_en_pulse) n_tx_en++;
        if (wr_drop)     n_drop++;
        if (wr_trunc)    n_trunc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Length the transmitter is told for a packet of n accepted bytes.
    function automatic int model_len(input int n);
        if (PAD_EN && n < MIN_LEN) return MIN_LEN;
        return n;
    endfunction

    // Byte stream the transmitter should read back: accepted bytes, then zero padding.
    function automatic byte_q_t model_stream(input byte_q_t accepted);
        byte_q_t s;
        int      len;
        len = model_len(accepted.size());
        for (int k = 0; k < len; k++) begin
            s.push_back((k < accepted.size()) ? accepted[k] : 8'h00);
        end
        return s;
    endfunction

    function automatic byte_q_t rand_pkt(input int n);
        byte_q_t p;
        for (int k = 0; k < n; k++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic write_pkt(input byte_q_t pkt);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk_125m);
            wr_en   = 1'b1;
            wr_data = pkt[i];
            wr_last = (i == pkt.size() - 1);
        end
        @(negedge clk_125m);
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic wait_launch(input string tag, input int exp_len);
        int cyc;
        cyc = 0;
        while (!tx_en_pulse && cyc < 20) begin
            @(negedge clk_125m);
            cyc++;
        end
        check($sformatf("%s_tx_en", tag), 32'(tx_en_pulse), 32'd1);
        check($sformatf("%s_data_len", tag), 32'(data_len), 32'(exp_len));
        check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s_wr_ready_low", tag), 32'(wr_ready), 32'd0);
    endtask

    task automatic read_pkt(input string tag, input byte_q_t exp_s, input int extra);
        for (int k = 0; k < exp_s.size() + extra; k++) begin
            @(negedge clk_125m);
            payload_req = 1'b1;
            #1;
            check($sformatf("%s_byte%0d", tag, k), 32'(payload_dat),
                  32'((k < exp_s.size()) ? exp_s[k] : 8'h00));
        end
        @(negedge clk_125m);
        payload_req = 1'b0;
    endtask

    task automatic finish_pkt(input string tag, input int exp_len, input bit wr_with_done);
        int d0;
        @(negedge clk_125m);
        check($sformatf("%s_wait_busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s_len_held", tag), 32'(data_len), 32'(exp_len));
        d0      = n_drop;
        tx_done = 1'b1;
        wr_en   = wr_with_done;
        wr_data = 8'($urandom);
        @(negedge clk_125m);
        tx_done = 1'b0;
        wr_en   = 1'b0;
        #1;
        check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_idle_ready", tag), 32'(wr_ready), 32'd1);
        if (wr_with_done) check($sformatf("%s_done_drop", tag), 32'(n_drop - d0), 32'd1);
    endtask

    task automatic full_packet(input string tag, input byte_q_t pkt, input bit wr_with_done);
        byte_q_t exp_s;
        exp_s = model_stream(pkt);
        write_pkt(pkt);
        wait_launch(tag, exp_s.size());
        read_pkt(tag, exp_s, 0);
        finish_pkt(tag, exp_s.size(), wr_with_done);
    endtask

    initial begin
        byte_q_t pkt;
        byte_q_t acc;
        byte_q_t exp_s;
        int      exp_launch;
        int      d0;
        int      t0;
        int      tx0;
        int      trunc_idx;
        int      launch_len;

        exp_launch = 0;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_125m);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        check("rst_wr_trunc", 32'(wr_trunc), 32'd0);
        check("rst_tx_en", 32'(tx_en_pulse), 32'd0);
        check("rst_data_len", 32'(data_len), 32'd0);
        check("rst_payload_dat", 32'(payload_dat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_125m);

        // "Hello"
        tx0 = n_tx_en;
        pkt = {8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        full_packet("hello", pkt, 1'b0);
        exp_launch++;
        #1 check("hello_one_launch", 32'(n_tx_en - tx0), 32'd1);

        // Single-byte packet goes straight from IDLE to LAUNCH
        full_packet("one_byte", rand_pkt(1), 1'b0);
        exp_launch++;

        // Random packets; last one has a write colliding with tx_done in WAIT_DONE
        for (int p = 0; p < 4; p++) begin
            full_packet($sformatf("rand%0d", p), rand_pkt($urandom_range(2, 40)), (p == 3));
            exp_launch++;
        end

        // Writes during SEND are dropped and leave the buffer intact
        pkt   = rand_pkt(8);
        exp_s = model_stream(pkt);
        write_pkt(pkt);
        wait_launch("send_wr", exp_s.size());
        exp_launch++;
        d0 = n_drop;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_125m);
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            #1 check($sformatf("send_wr_ready%0d", i), 32'(wr_ready), 32'd0);
        end
        @(negedge clk_125m);
        wr_en = 1'b0;
        #1 check("send_wr_drops", 32'(n_drop - d0), 32'd5);
        read_pkt("send_wr", exp_s, 0);
        finish_pkt("send_wr", exp_s.size(), 1'b0);

        // Requests held past data_len read zeros and leave the FSM waiting for tx_done
        pkt   = rand_pkt(4);
        exp_s = model_stream(pkt);
        write_pkt(pkt);
        wait_launch("over_req", exp_s.size());
        exp_launch++;
        read_pkt("over_req", exp_s, 3);
        finish_pkt("over_req", exp_s.size(), 1'b0);

        // 1500 bytes with no wr_last: truncates at MAX_LEN, remainder dropped
        pkt = rand_pkt(1500);
        acc = {};
        for (int i = 0; i < MAX_LEN; i++) acc.push_back(pkt[i]);
        d0         = n_drop;
        t0         = n_trunc;
        trunc_idx  = -1;
        launch_len = -1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_125m);
            if (wr_trunc) trunc_idx = i - 1;
            if (tx_en_pulse) launch_len = int'(data_len);
            wr_en   = 1'b1;
            wr_data = pkt[i];
            wr_last = 1'b0;
        end
        @(negedge clk_125m);
        wr_en = 1'b0;
        #1;
        exp_launch++;
        check("trunc_index", 32'(trunc_idx), 32'(MAX_LEN - 1));
        check("trunc_pulses", 32'(n_trunc - t0), 32'd1);
        check("trunc_launch_len", 32'(launch_len), 32'(MAX_LEN));
        check("trunc_drops", 32'(n_drop - d0), 32'(1500 - MAX_LEN));
        exp_s = model_stream(acc);
        read_pkt("trunc", exp_s, 0);
        finish_pkt("trunc", MAX_LEN, 1'b0);

        // Exactly MAX_LEN bytes with wr_last: no truncation; tx_done aborts from SEND
        pkt = rand_pkt(MAX_LEN);
        t0  = n_trunc;
        write_pkt(pkt);
        wait_launch("exact_max", MAX_LEN);
        exp_launch++;
        #1 check("exact_max_no_trunc", 32'(n_trunc - t0), 32'd0);
        @(negedge clk_125m);
        tx_done = 1'b1;
        @(negedge clk_125m);
        tx_done = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(wr_ready), 32'd1);

        // Reset in the middle of a packet discards it without a launch
        tx0 = n_tx_en;
        pkt = rand_pkt(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_125m);
            wr_en   = 1'b1;
            wr_data = pkt[i];
        end
        @(negedge clk_125m);
        wr_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_125m);
        rst_n = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(wr_ready), 32'd1);
        check("midrst_data_len", 32'(data_len), 32'd0);
        check("midrst_payload_dat", 32'(payload_dat), 32'd0);
        repeat (5) @(negedge clk_125m);
        #1 check("midrst_no_launch", 32'(n_tx_en - tx0), 32'd0);
        full_packet("after_rst", rand_pkt(3), 1'b0);
        exp_launch++;

        #1 check("total_launches", 32'(n_tx_en), 32'(exp_launch));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
